// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: registered state, memory-ready wait states,
// illegal-opcode trap and a retired-instruction counter.
module multicycle_control_fsm #(
    parameter bit MEM_WAIT = 1'b1,
    parameter bit EXC_EN   = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             pc_write_cond_ne,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic [1:0]       pc_source,
    output logic [1:0]       alu_op,
    output logic [1:0]       alu_src_b,
    output logic             alu_src_a,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             epc_write,
    output logic             cause_write,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;
    localparam logic [1:0] ALU_SUB      = 2'b01;
    localparam logic [1:0] ALU_FUNCT    = 2'b10;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11,
        S_BNE    = 4'd12,
        S_EXC    = 4'd13
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       epc_write;
        logic       cause_write;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op);
        logic legal;
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI: legal = 1'b1;
            default:                                           legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    ctrl_t            ctrl_s;
    ctrl_t            ctrl_gated_s;
    logic             ready_s;

    assign ready_s = mem_ready | ~MEM_WAIT;

    // Next-state selection; opcode is only consulted in DECODE and MEMADR.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: begin
                if (ready_s) state_d = S_DECODE;
                else         state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_BNE:       state_d = S_BNE;
                    default: begin
                        if (EXC_EN) state_d = S_EXC;
                        else        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW) state_d = S_MEMWR;
                else                 state_d = S_MEMRD;
            end
            S_MEMRD: begin
                if (ready_s) state_d = S_MEMWB;
                else         state_d = S_MEMRD;
            end
            S_MEMWR: begin
                if (ready_s) state_d = S_FETCH;
                else         state_d = S_MEMWR;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BEQ, S_JUMP, S_ADDIWB, S_BNE, S_EXC: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // Control word decoded from the current state.
    always_comb begin
        ctrl_s = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_s.mem_read  = 1'b1;
                ctrl_s.alu_src_b = SRCB_FOUR;
                if (ready_s) begin
                    ctrl_s.ir_write = 1'b1;
                    ctrl_s.pc_write = 1'b1;
                end else begin
                    ctrl_s.ir_write = 1'b0;
                    ctrl_s.pc_write = 1'b0;
                end
            end
            S_DECODE: begin
                ctrl_s.alu_src_b = SRCB_IMM_SH2;
                if (!op_legal(opcode) && !EXC_EN) ctrl_s.instr_done = 1'b1;
                else                              ctrl_s.instr_done = 1'b0;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl_s.mem_read = 1'b1;
                ctrl_s.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.mem_to_reg = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl_s.mem_write  = 1'b1;
                ctrl_s.iord       = 1'b1;
                ctrl_s.instr_done = ready_s;
            end
            S_EXEC: begin
                ctrl_s.alu_src_a = 1'b1;
                ctrl_s.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.reg_dst    = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ctrl_s.alu_src_a  = 1'b1;
                ctrl_s.alu_op     = ALU_SUB;
                ctrl_s.pc_source  = PCSRC_ALUOUT;
                ctrl_s.instr_done = 1'b1;
                if (state_q == S_BNE) ctrl_s.pc_write_cond_ne = 1'b1;
                else                  ctrl_s.pc_write_cond    = 1'b1;
            end
            S_JUMP: begin
                ctrl_s.pc_write   = 1'b1;
                ctrl_s.pc_source  = PCSRC_JUMP;
                ctrl_s.instr_done = 1'b1;
            end
            S_ADDIWB: begin
                ctrl_s.reg_write  = 1'b1;
                ctrl_s.instr_done = 1'b1;
            end
            S_EXC: begin
                ctrl_s.epc_write   = 1'b1;
                ctrl_s.cause_write = 1'b1;
                ctrl_s.pc_write    = 1'b1;
                ctrl_s.pc_source   = PCSRC_EXC;
                ctrl_s.instr_done  = 1'b1;
            end
            default: ctrl_s = '0;
        endcase
    end

    // Reset silences every control output, which also freezes the counter.
    always_comb begin
        if (rst_n) ctrl_gated_s = ctrl_s;
        else       ctrl_gated_s = '0;
        count_d = count_q + CNT_W'(ctrl_gated_s.instr_done);
    end

    // State and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign pc_write         = ctrl_gated_s.pc_write;
    assign pc_write_cond    = ctrl_gated_s.pc_write_cond;
    assign pc_write_cond_ne = ctrl_gated_s.pc_write_cond_ne;
    assign iord             = ctrl_gated_s.iord;
    assign mem_read         = ctrl_gated_s.mem_read;
    assign mem_write        = ctrl_gated_s.mem_write;
    assign ir_write         = ctrl_gated_s.ir_write;
    assign mem_to_reg       = ctrl_gated_s.mem_to_reg;
    assign pc_source        = ctrl_gated_s.pc_source;
    assign alu_op           = ctrl_gated_s.alu_op;
    assign alu_src_b        = ctrl_gated_s.alu_src_b;
    assign alu_src_a        = ctrl_gated_s.alu_src_a;
    assign reg_write        = ctrl_gated_s.reg_write;
    assign reg_dst          = ctrl_gated_s.reg_dst;
    assign epc_write        = ctrl_gated_s.epc_write;
    assign cause_write      = ctrl_gated_s.cause_write;
    assign instr_done       = ctrl_gated_s.instr_done;
    assign state            = state_q;
    assign instr_count      = count_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: the driver pushes each instruction's expected state path,
// latency and counter value; a negedge monitor pops and checks them.
module tb_multicycle_control_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    // Control word bit masks: {pc_write, pc_write_cond, pc_write_cond_ne, iord,
    // mem_read, mem_write, ir_write, mem_to_reg, pc_source, alu_op, alu_src_b,
    // alu_src_a, reg_write, reg_dst, epc_write, cause_write, instr_done}
    localparam logic [19:0] PCW       = 20'h80000;
    localparam logic [19:0] PWC       = 20'h40000;
    localparam logic [19:0] PWCNE     = 20'h20000;
    localparam logic [19:0] IORD      = 20'h10000;
    localparam logic [19:0] MRD       = 20'h08000;
    localparam logic [19:0] MWR       = 20'h04000;
    localparam logic [19:0] IRW       = 20'h02000;
    localparam logic [19:0] M2R       = 20'h01000;
    localparam logic [19:0] PC_ALUOUT = 20'h00400;
    localparam logic [19:0] PC_JUMP   = 20'h00800;
    localparam logic [19:0] PC_EXC    = 20'h00C00;
    localparam logic [19:0] ALU_SUB   = 20'h00100;
    localparam logic [19:0] ALU_FN    = 20'h00200;
    localparam logic [19:0] SB_FOUR   = 20'h00040;
    localparam logic [19:0] SB_IMM    = 20'h00080;
    localparam logic [19:0] SB_IMM2   = 20'h000C0;
    localparam logic [19:0] SRCA      = 20'h00020;
    localparam logic [19:0] RW        = 20'h00010;
    localparam logic [19:0] RDST      = 20'h00008;
    localparam logic [19:0] EPC       = 20'h00004;
    localparam logic [19:0] CAUSE     = 20'h00002;
    localparam logic [19:0] DONE      = 20'h00001;

    typedef struct packed {
        logic [7:0]       len;
        logic [23:0][3:0] path;
        logic [31:0]      cnt;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst1_n, rst2_n, mem_ready;
    logic [5:0]  opcode;
    bit          sel;        // 0: dut1 (waits, traps, 4-bit count); 1: dut2 (no waits, NOP)
    bit          done_flag;
    int          n_checks, n_err;
    logic [31:0] model_cnt;
    rec_t        sbq[$];

    wire [19:0] w1, w2;
    wire [3:0]  st1, st2;
    wire [3:0]  cnt1;
    wire [31:0] cnt2;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.MEM_WAIT(1'b1), .EXC_EN(1'b1), .CNT_W(4)) u1 (
        .clk(clk), .rst_n(rst1_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(w1[19]), .pc_write_cond(w1[18]), .pc_write_cond_ne(w1[17]),
        .iord(w1[16]), .mem_read(w1[15]), .mem_write(w1[14]), .ir_write(w1[13]),
        .mem_to_reg(w1[12]), .pc_source(w1[11:10]), .alu_op(w1[9:8]),
        .alu_src_b(w1[7:6]), .alu_src_a(w1[5]), .reg_write(w1[4]), .reg_dst(w1[3]),
        .epc_write(w1[2]), .cause_write(w1[1]), .state(st1), .instr_done(w1[0]),
        .instr_count(cnt1)
    );

    multicycle_control_fsm #(.MEM_WAIT(1'b0), .EXC_EN(1'b0), .CNT_W(32)) u2 (
        .clk(clk), .rst_n(rst2_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(w2[19]), .pc_write_cond(w2[18]), .pc_write_cond_ne(w2[17]),
        .iord(w2[16]), .mem_read(w2[15]), .mem_write(w2[14]), .ir_write(w2[13]),
        .mem_to_reg(w2[12]), .pc_source(w2[11:10]), .alu_op(w2[9:8]),
        .alu_src_b(w2[7:6]), .alu_src_a(w2[5]), .reg_write(w2[4]), .reg_dst(w2[3]),
        .epc_write(w2[2]), .cause_write(w2[1]), .state(st2), .instr_done(w2[0]),
        .instr_count(cnt2)
    );

    wire [19:0] cur_w   = sel ? w2 : w1;
    wire [3:0]  cur_st  = sel ? st2 : st1;
    wire [31:0] cur_cnt = sel ? cnt2 : {28'd0, cnt1};
    wire        cur_rst = sel ? rst2_n : rst1_n;

    function automatic bit legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_BNE) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    // Required control word for a state, from the state table.
    function automatic logic [19:0] spec_word(input logic [3:0] st, input bit rdy,
                                              input logic [5:0] op, input bit exc_en);
        case (st)
            4'd0:  return MRD | SB_FOUR | (rdy ? (IRW | PCW) : 20'h0);
            4'd1:  return SB_IMM2 | ((!legal(op) && !exc_en) ? DONE : 20'h0);
            4'd2:  return SRCA | SB_IMM;
            4'd3:  return MRD | IORD;
            4'd4:  return RW | M2R | DONE;
            4'd5:  return MWR | IORD | (rdy ? DONE : 20'h0);
            4'd6:  return SRCA | ALU_FN;
            4'd7:  return RW | RDST | DONE;
            4'd8:  return SRCA | ALU_SUB | PWC | PC_ALUOUT | DONE;
            4'd9:  return PCW | PC_JUMP | DONE;
            4'd10: return SRCA | SB_IMM;
            4'd11: return RW | DONE;
            4'd12: return SRCA | ALU_SUB | PWCNE | PC_ALUOUT | DONE;
            4'd13: return EPC | CAUSE | PCW | PC_EXC | DONE;
            default: return 20'h0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t sel=%0d)", name, act, exp, $time, sel);
        end
    endtask

    // Drive one instruction: FETCH waits wf, data-memory waits wm; abort_at>=0 resets in that cycle.
    task automatic run_instr(input logic [5:0] op, input int wf, input int wm, input int abort_at);
        logic [3:0] ph_st[$];
        bit         ph_mem[$];
        logic [3:0] cyc_st[$];
        bit         cyc_rdy[$];
        rec_t       r;
        bit         mw, ex;
        int         w;
        mw = !sel;
        ex = !sel;
        ph_st  = '{4'd0, 4'd1};
        ph_mem = '{1'b1, 1'b0};
        case (op)
            OP_LW:   begin ph_st = {ph_st, 4'd2, 4'd3, 4'd4}; ph_mem = {ph_mem, 1'b0, 1'b1, 1'b0}; end
            OP_SW:   begin ph_st = {ph_st, 4'd2, 4'd5};       ph_mem = {ph_mem, 1'b0, 1'b1}; end
            OP_R:    begin ph_st = {ph_st, 4'd6, 4'd7};       ph_mem = {ph_mem, 1'b0, 1'b0}; end
            OP_BEQ:  begin ph_st = {ph_st, 4'd8};             ph_mem = {ph_mem, 1'b0}; end
            OP_BNE:  begin ph_st = {ph_st, 4'd12};            ph_mem = {ph_mem, 1'b0}; end
            OP_J:    begin ph_st = {ph_st, 4'd9};             ph_mem = {ph_mem, 1'b0}; end
            OP_ADDI: begin ph_st = {ph_st, 4'd10, 4'd11};     ph_mem = {ph_mem, 1'b0, 1'b0}; end
            default: begin
                if (ex) begin ph_st = {ph_st, 4'd13}; ph_mem = {ph_mem, 1'b0}; end
            end
        endcase
        for (int p = 0; p < ph_st.size(); p++) begin
            w = (p == 0) ? wf : wm;
            if (ph_mem[p] && mw) begin
                for (int k = 0; k < w; k++) begin
                    cyc_st.push_back(ph_st[p]);
                    cyc_rdy.push_back(1'b0);
                end
                cyc_st.push_back(ph_st[p]);
                cyc_rdy.push_back(1'b1);
            end else begin
                cyc_st.push_back(ph_st[p]);
                cyc_rdy.push_back(1'($urandom_range(0, 1)));
            end
        end
        r.len  = 8'(cyc_st.size());
        r.path = '0;
        for (int k = 0; k < cyc_st.size(); k++) r.path[k] = cyc_st[k];
        r.cnt = (model_cnt + 32'd1) & (sel ? 32'hFFFF_FFFF : 32'h0000_000F);
        sbq.push_back(r);
        opcode = op;
        for (int i = 0; i < cyc_st.size(); i++) begin
            if (i == abort_at) begin
                if (sel) rst2_n = 1'b0; else rst1_n = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                if (sel) rst2_n = 1'b1; else rst1_n = 1'b1;
                model_cnt = 32'd0;
                return;
            end
            mem_ready = cyc_rdy[i];
            @(posedge clk);
            #1;
        end
        model_cnt = r.cnt;
    endtask

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [7];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_ADDI};
        if ($urandom_range(0, 9) < 7) return ops[$urandom_range(0, 6)];
        return 6'($urandom_range(0, 63));
    endfunction

    // Monitor: compares the selected DUT against the head scoreboard entry every cycle.
    initial begin : monitor
        int          c;
        bit          pend, was_rst;
        logic [31:0] pv;
        rec_t        rec;
        c = 0; pend = 1'b0; was_rst = 1'b0; pv = 32'd0;
        forever begin
            @(negedge clk);
            if (done_flag) break;
            if (!cur_rst) begin
                chk("reset_outputs", {12'd0, cur_w}, 32'd0);
                if (was_rst) begin
                    chk("reset_state", {28'd0, cur_st}, 32'd0);
                    chk("reset_count", cur_cnt, 32'd0);
                end
                sbq.delete();
                c = 0; pend = 1'b0; was_rst = 1'b1;
            end else begin
                was_rst = 1'b0;
                if (pend) begin
                    chk("instr_count", cur_cnt, pv);
                    pend = 1'b0;
                end
                if (sbq.size() != 0) begin
                    rec = sbq[0];
                    chk("state_path", {28'd0, cur_st}, {28'd0, rec.path[c]});
                    chk("ctrl_word", {12'd0, cur_w},
                        {12'd0, spec_word(rec.path[c], mem_ready | sel, opcode, !sel)});
                    if (cur_w[0]) begin
                        chk("latency", 32'(c + 1), {24'd0, rec.len});
                        pend = 1'b1;
                        pv = rec.cnt;
                        void'(sbq.pop_front());
                        c = 0;
                    end else begin
                        c++;
                        if (c >= int'(rec.len)) begin
                            chk("instr_done_missing", 32'(c), {24'd0, rec.len} - 32'd1);
                            void'(sbq.pop_front());
                            c = 0;
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        n_checks = 0; n_err = 0; done_flag = 1'b0; sel = 1'b0;
        rst1_n = 1'b0; rst2_n = 1'b0; mem_ready = 1'b0; opcode = OP_R;
        model_cnt = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        rst1_n = 1'b1;
        run_instr(OP_LW, 0, 0, -1);
        run_instr(OP_SW, 0, 3, -1);
        run_instr(OP_BNE, 0, 0, -1);
        run_instr(OP_BEQ, 0, 0, -1);
        run_instr(6'b111111, 0, 0, -1);
        run_instr(OP_LW, 2, 3, -1);
        run_instr(OP_R, 0, 0, 2);
        for (int i = 0; i < 16; i++) run_instr(OP_J, 0, 0, -1);
        run_instr(OP_ADDI, 0, 0, -1);
        for (int i = 0; i < 40; i++)
            run_instr(rand_op(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
        rst1_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        sel = 1'b1;
        model_cnt = 32'd0;
        rst2_n = 1'b1;
        run_instr(6'b111111, 0, 0, -1);
        run_instr(OP_LW, 0, 0, -1);
        run_instr(OP_SW, 0, 0, -1);
        run_instr(OP_ADDI, 0, 0, -1);
        for (int i = 0; i < 20; i++) run_instr(rand_op(), 0, 0, -1);
        rst2_n = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        done_flag = 1'b1;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Registered-state successor to the combinational multicycle MIPS control decoder. It holds its own 4-bit state register and adds `bne` and `addi`. It inserts wait states on a memory-ready handshake, traps illegal opcodes, and counts retired instructions. It sits between the instruction register's opcode field and the multicycle datapath's muxes and write enables.

## Interface
- `MEM_WAIT`, default 1: 1 means memory states wait on `mem_ready`; 0 means `mem_ready` is ignored and treated as 1.
- `EXC_EN`, default 1: 1 means an illegal opcode enters EXC; 0 means an illegal opcode returns to FETCH as a NOP.
- `CNT_W`, default 32: width of the retired-instruction counter.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `opcode` in 6: IR[31:26]; stable from DECODE to the end of the instruction.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `pc_write`, `pc_write_cond`, `pc_write_cond_ne` out 1: PC enables. The datapath writes PC on `pc_write | (pc_write_cond & zero) | (pc_write_cond_ne & ~zero)`.
- `iord`, `mem_read`, `mem_write`, `ir_write`, `mem_to_reg` out 1 each: memory, IR and write-back source controls.
- `pc_source` out 2: 00 ALU, 01 ALUOut, 10 jump target, 11 exception vector.
- `alu_op` out 2: 00 add, 01 sub, 10 funct.
- `alu_src_b` out 2: 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- `alu_src_a`, `reg_write`, `reg_dst` out 1 each.
- `epc_write`, `cause_write` out 1 each: exception register enables.
- `state` out 4: current state, for debug.
- `instr_done` out 1: high in the final cycle of each instruction.
- `instr_count` out CNT_W: number of retired instructions.

## Operation
Opcodes: R 000000, lw 100011, sw 101011, beq 000100, bne 000101, j 000010, addi 001000. Any other opcode is illegal.

States and transitions (encoding in parentheses). Any output not listed for a state is 0.
- FETCH (0): `mem_read`=1, `alu_src_b`=01. Goes to DECODE when ready; until then `ir_write`=0, `pc_write`=0 and the FSM stays in FETCH. Once ready, `ir_write`=1 and `pc_write`=1 in that same cycle.
- DECODE (1): `alu_src_b`=11. Next state by opcode:
  - lw or sw → MEMADR (2)
  - R → EXEC (6)
  - beq → BEQ (8)
  - j → JUMP (9)
  - addi → ADDIEX (10)
  - bne → BNE (12)
  - illegal → EXC (13), or FETCH when `EXC_EN`=0; the FETCH case asserts `instr_done`.
- MEMADR (2): `alu_src_a`=1, `alu_src_b`=10. lw → MEMRD (3); sw → MEMWR (5).
- MEMRD (3): `mem_read`=1, `iord`=1. Goes to MEMWB (4) when ready; holds otherwise.
- MEMWB (4): `reg_write`=1, `mem_to_reg`=1, `instr_done`=1. → FETCH.
- MEMWR (5): `mem_write`=1, `iord`=1. When ready, `instr_done`=1 and → FETCH; holds otherwise.
- EXEC (6): `alu_src_a`=1, `alu_op`=10. → ALUWB (7).
- ALUWB (7): `reg_write`=1, `reg_dst`=1, `instr_done`=1. → FETCH.
- BEQ (8): `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01, `instr_done`=1. → FETCH.
- JUMP (9): `pc_write`=1, `pc_source`=10, `instr_done`=1. → FETCH.
- ADDIEX (10): `alu_src_a`=1, `alu_src_b`=10. → ADDIWB (11).
- ADDIWB (11): `reg_write`=1, `instr_done`=1. → FETCH.
- BNE (12): same as BEQ, except `pc_write_cond_ne`=1 replaces `pc_write_cond`. → FETCH.
- EXC (13): `epc_write`=1, `cause_write`=1, `pc_write`=1, `pc_source`=11, `instr_done`=1. → FETCH.
- Encodings 14 and 15 are unreachable; if entered they go to FETCH with all outputs 0.

Behaviour rules:
- "Ready" means `mem_ready`=1, or `MEM_WAIT`=0.
- `instr_count` increments by 1 on every clock edge where `instr_done`=1 and `rst_n`=1. It wraps modulo 2^CNT_W.
- EXC counts as retired.

## Timing
- Reset: on a rising edge with `rst_n`=0, `state` becomes FETCH and `instr_count` becomes 0.
  - While `rst_n`=0, all control outputs and `instr_done` are forced to 0.
  - The first FETCH outputs appear in the cycle after `rst_n` rises.
  - Reset asserted mid-instruction abandons the instruction; it is not counted.
- Outputs are decoded combinationally from `state`. Only FETCH `ir_write`/`pc_write`, MEMWR `instr_done`, and the DECODE-NOP `instr_done` also depend on `mem_ready` or `opcode`.
- Latency without wait states, counted from FETCH to the FETCH after:
  - lw: 5 cycles
  - R, sw, addi: 4 cycles
  - beq, bne, j, illegal (EXC): 3 cycles
  - illegal with `EXC_EN`=0: 2 cycles
- Each cycle of `mem_ready`=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
- `mem_read`/`mem_write` are held steady throughout a wait.
- `opcode` is sampled only in DECODE and MEMADR.

## Test plan
- Reset, then `rst_n`=1, `mem_ready`=1, opcode 100011 → `state` sequence 0,1,2,3,4,0; `reg_write`=`mem_to_reg`=1 in state 4; `instr_count`=1.
- sw (101011) with `mem_ready`=0 for 3 cycles in state 5 → `mem_write`=1 held for 4 cycles, single `instr_done` pulse, total 7 cycles.
- bne (000101) then beq (000100) → `state` 0,1,12,0,1,8,0; `pc_write_cond_ne`=1 only in 12, `pc_write_cond`=1 only in 8; `instr_count`=2.
- opcode 111111 with `EXC_EN`=1 → `state` 0,1,13,0; `epc_write`=`cause_write`=`pc_write`=1 and `pc_source`=11 in 13. With `EXC_EN`=0 → `state` 0,1,0 with `instr_done` high in state 1.
- R-type (000000) with `rst_n` pulled low in state 6 → next `state`=0, `instr_count`=0, all outputs 0 during reset.
- `CNT_W`=4, 16 back-to-back j (000010) → `instr_count` wraps to 0; `addi` (001000) → `state` 0,1,10,11,0 with `alu_src_b`=10 in 10 and `reg_write`=1, `reg_dst`=0 in 11.
